// File: rtl/result_serializer.sv
// Frames a captured encrypted result (10 bytes) or password (8 bytes) behind a
// one-byte header and streams it MSB first over a valid/ready byte interface.
module result_serializer #(
  parameter logic [7:0] HDR_ENC = 8'hE5,
  parameter logic [7:0] HDR_PWD = 8'hB0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        sel,
  input  logic [75:0] data_96,
  input  logic [59:0] data_80,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic        drop_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [79:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;
  logic        xfer_s;
  logic [3:0]  last_cnt_s;

  // State and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      shift_q <= 80'd0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign xfer_s     = byte_valid & byte_ready;
  assign last_cnt_s = sel_q ? 4'd7 : 4'd9;

  // Next-state logic: capture, header/payload sequencing, drop detection.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = HDR;
          sel_d   = sel;
          cnt_d   = 4'd0;
          // The password is left-aligned so both payloads leave from bits [79:72].
          shift_d = sel ? {4'b0000, data_80, 16'h0000} : {4'b0000, data_96};
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (xfer_s) begin
          state_d = DATA;
        end else begin
          state_d = HDR;
        end
      end
      DATA: begin
        if (xfer_s) begin
          if (cnt_q == last_cnt_s) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            shift_d = {shift_q[71:0], 8'h00};
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load && (state_q != IDLE)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    byte_out   = 8'h00;
    byte_valid = 1'b0;
    case (state_q)
      HDR: begin
        byte_valid = 1'b1;
        byte_out   = sel_q ? HDR_PWD : HDR_ENC;
      end
      DATA: begin
        byte_valid = 1'b1;
        byte_out   = shift_q[79:72];
      end
      default: begin
        byte_valid = 1'b0;
        byte_out   = 8'h00;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign drop_err = drop_q;

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter HDR_ENC, default 8'hE5: header byte sent before an encrypted-result frame.
REQ-002 Parameter HDR_PWD, default 8'hB0: header byte sent before a password frame.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  request to capture a result for serialization.
REQ-006 sel  input  1  source select at load: 0 = encrypted result (data_96), 1 = password (data_80).
REQ-007 data_96  input  76  encrypted result from the encrypter stage.
REQ-008 data_80  input  60  password from the password generator stage.
REQ-009 byte_out  output  8  current output byte.
REQ-010 byte_valid  output  1  byte_out holds a valid byte.
REQ-011 byte_ready  input  1  downstream accepts byte_out.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  one-cycle pulse after the last byte of a frame transfers.
REQ-014 drop_err  output  1  sticky flag: a load was ignored.

Function
REQ-015 States SHALL be IDLE, HDR and DATA; busy = (state != IDLE).
REQ-016 In IDLE, load=1 at a rising edge SHALL accept: capture sel, capture {4'b0,data_96} (80 bits, 10 bytes) when sel=0 or {4'b0,data_80} (64 bits, 8 bytes) when sel=1, and go to HDR.
REQ-017 In HDR, byte_valid SHALL be 1 and byte_out SHALL be HDR_ENC when sel=0 or HDR_PWD when sel=1.
REQ-018 In DATA, byte_valid SHALL be 1 and byte_out SHALL be the most significant unsent byte of the captured word; bytes go out MSB first.
REQ-019 A transfer SHALL occur on a rising edge with byte_valid=1 and byte_ready=1; only a transfer advances HDR->DATA or to the next byte.
REQ-020 While byte_valid=1 and byte_ready=0, byte_out SHALL hold stable.
REQ-021 A per-frame byte counter SHALL count payload transfers.
REQ-022 The transfer of payload byte 10 (sel=0) or byte 8 (sel=1) SHALL move the block to IDLE and set done=1 for the next cycle only.
REQ-023 Latency: first header byte valid in the cycle after load is accepted; minimum frame time is 11 (sel=0) or 9 (sel=1) cycles with byte_ready tied to 1.
REQ-024 load=1 in the done cycle SHALL be accepted normally, giving back-to-back frames.
REQ-025 load=1 while busy=1 SHALL be ignored; the in-flight frame SHALL be unaffected and drop_err SHALL be set.
REQ-026 drop_err SHALL stay set until reset.
REQ-027 data_96, data_80 and sel SHALL be ignored except at an accepted load.
REQ-028 byte_valid SHALL be 0 in IDLE, and byte_out SHALL be 8'h00 in IDLE.

Reset
REQ-029 Rst_n=0 SHALL immediately force: state IDLE, byte_out=8'h00, byte_valid=0, busy=0, done=0, drop_err=0, counter=0, capture register=0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; the first load after Rst_n rises SHALL start a fresh frame.

Verification
REQ-031 Encrypted frame: sel=0, data_96=76'hABC_DEF0_1234_5678_9ABC, load 1 cycle, byte_ready=1 -> bytes E5,0A,BC,DE,F0,12,34,56,78,9A,BC on 11 consecutive cycles, then done=1 for one cycle and busy=0.
REQ-032 Password frame: sel=1, data_80=60'h123_4567_89AB_CDEF -> bytes B0,01,23,45,67,89,AB,CD,EF, then done pulse; 9 bytes in total.
REQ-033 Backpressure: byte_ready toggles 1/0 randomly during REQ-031 -> identical byte sequence, each byte held stable while stalled, done only after byte 10.
REQ-034 Drop: during a frame, pulse load with different data -> frame bytes unchanged and drop_err=1 until reset.
REQ-035 Back-to-back: load asserted in the done cycle with sel=1 -> the next cycle shows B0 with busy=1.
REQ-036 Reset mid-frame: Rst_n=0 after 4 transfers -> all outputs reach reset values without waiting for a clock edge and no done pulse; a subsequent load frames correctly from the header.
